// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable clock-enable generator, one CE pulse every DIV+1 clocks with run/stop and manual step
// Ports: CLK clock; RESET sync active-high; DIV period minus one; RUN level enable; STEP manual step (rising edge);
//   CE registered one-cycle tick; COUNT divider count; RUNNING state flag; TICKS pulse count.
// Optional: define TICK_PRESCALER_TICKCNT_EN to build the TICKS counter, otherwise TICKS is tied to 0.
module tick_prescaler #(
  parameter int WIDTH = 22,
  parameter int TICKW = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIV,
  input  logic             RUN,
  input  logic             STEP,
  output logic             CE,
  output logic [WIDTH-1:0] COUNT,
  output logic             RUNNING,
  output logic [TICKW-1:0] TICKS
);
  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
  logic             ce_q, ce_d, step_q;
  // period is latched only while stopped or at a tick, so a period in progress keeps its length
  always_comb begin
    state_d  = state_q;
    count_d  = '0;
    period_d = period_q;
    ce_d     = 1'b0;
    if (state_q == ST_STOP) begin
      period_d = DIV;
      state_d  = RUN ? ST_RUN : ST_STOP;
      ce_d     = !RUN && STEP && !step_q;
    end else if (!RUN) begin
      state_d = ST_STOP;
    end else if (count_q == period_q) begin
      ce_d     = 1'b1;
      period_d = DIV;
    end else begin
      count_d = count_q + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_STOP;
      count_q  <= '0;
      period_q <= DIV;
      ce_q     <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      ce_q     <= ce_d;
      step_q   <= STEP;
    end
  end
  assign CE      = ce_q;
  assign COUNT   = count_q;
  assign RUNNING = (state_q == ST_RUN);
`ifdef TICK_PRESCALER_TICKCNT_EN
  logic [TICKW-1:0] ticks_q;
  always_ff @(posedge CLK) begin
    if (RESET) ticks_q <= '0;
    else if (ce_d) ticks_q <= ticks_q + 1'b1;
  end
  assign TICKS = ticks_q;
`else
  assign TICKS = '0;
`endif
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed scoreboard bench for tick_prescaler
module tb_tick_prescaler;
  localparam int W  = 22;
  localparam int TW = 8;
  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [W-1:0]  DIV = '0;
  logic          RUN = 1'b0;
  logic          STEP = 1'b0;
  logic          CE;
  logic [W-1:0]  COUNT;
  logic          RUNNING;
  logic [TW-1:0] TICKS;
  typedef struct {
    logic          ce;
    logic [W-1:0]  cnt;
    logic          rn;
    logic [TW-1:0] tk;
    string         tag;
  } exp_t;
  exp_t          sb[$];
  logic [TW-1:0] exp_ticks = '0;
  int            checks = 0;
  int            errors = 0;
  tick_prescaler #(.WIDTH(W), .TICKW(TW)) dut (
    .CLK(CLK), .RESET(RESET), .DIV(DIV), .RUN(RUN), .STEP(STEP),
    .CE(CE), .COUNT(COUNT), .RUNNING(RUNNING), .TICKS(TICKS)
  );
  always #5 CLK = ~CLK;
  task automatic cyc(input logic rst, input logic run, input logic st, input logic [W-1:0] div,
                     input logic ce, input logic [W-1:0] cnt, input logic rn, input string tag);
    exp_t e;
    RESET = rst;
    RUN   = run;
    STEP  = st;
    DIV   = div;
`ifdef TICK_PRESCALER_TICKCNT_EN
    exp_ticks = rst ? '0 : exp_ticks + TW'(ce);
`endif
    sb.push_back('{ce, cnt, rn, exp_ticks, tag});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    checks++;
    assert (CE === e.ce) else begin errors++; $error("FAIL %s CE got %0b exp %0b", e.tag, CE, e.ce); end
    checks++;
    assert (COUNT === e.cnt) else begin errors++; $error("FAIL %s COUNT got %0d exp %0d", e.tag, COUNT, e.cnt); end
    checks++;
    assert (RUNNING === e.rn) else begin errors++; $error("FAIL %s RUNNING got %0b exp %0b", e.tag, RUNNING, e.rn); end
    checks++;
    assert (TICKS === e.tk) else begin errors++; $error("FAIL %s TICKS got %0d exp %0d", e.tag, TICKS, e.tk); end
  endtask
  initial begin
    logic [TW-1:0] want_final;
    @(posedge CLK);
    #1;
    cyc(1, 0, 0, 3, 0, 0, 0, "reset");
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 3, 0, 0, 0, "idle");
    cyc(0, 1, 0, 3, 0, 0, 1, "run_enter");
    for (int p = 0; p < 3; p++) begin
      cyc(0, 1, 0, 3, 0, 1, 1, "div3_c1");
      cyc(0, 1, 0, 3, 0, 2, 1, "div3_c2");
      cyc(0, 1, 0, 3, 0, 3, 1, "div3_c3");
      cyc(0, 1, 0, 3, 1, 0, 1, "div3_tick");
    end
    cyc(0, 1, 0, 0, 0, 1, 1, "div0_pend1");
    cyc(0, 1, 0, 0, 0, 2, 1, "div0_pend2");
    cyc(0, 1, 0, 0, 0, 3, 1, "div0_pend3");
    cyc(0, 1, 0, 0, 1, 0, 1, "div0_load");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0, 1, "div0_cont");
    cyc(0, 1, 0, 5, 1, 0, 1, "div5_load");
    for (int k = 1; k <= 5; k++) cyc(0, 1, 0, 5, 0, W'(k), 1, "div5_cnt");
    cyc(0, 1, 0, 5, 1, 0, 1, "div5_tick");
    cyc(0, 0, 0, 3, 0, 0, 0, "stop");
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 1, 3, 1, 0, 0, "step_pulse");
      cyc(0, 0, 1, 3, 0, 0, 0, "step_hold1");
      cyc(0, 0, 1, 3, 0, 0, 0, "step_hold2");
      cyc(0, 0, 0, 3, 0, 0, 0, "step_low1");
      cyc(0, 0, 0, 3, 0, 0, 0, "step_low2");
    end
    cyc(0, 1, 1, 3, 0, 0, 1, "run_wins_step");
    cyc(0, 1, 1, 3, 0, 1, 1, "step_ignored");
    cyc(0, 1, 0, 3, 0, 2, 1, "pre_stop2");
    cyc(0, 1, 0, 3, 0, 3, 1, "pre_stop3");
    cyc(0, 0, 0, 3, 0, 0, 0, "stop_at_period");
    cyc(0, 0, 0, 3, 0, 0, 0, "stopped_quiet");
    cyc(0, 1, 0, 3, 0, 0, 1, "rerun");
    cyc(0, 1, 0, 3, 0, 1, 1, "rerun_c1");
    cyc(0, 1, 0, 3, 0, 2, 1, "rerun_c2");
    cyc(1, 1, 0, 3, 0, 0, 0, "reset_mid");
    cyc(0, 0, 0, 3, 0, 0, 0, "after_reset");
    cyc(1, 0, 0, 0, 0, 0, 0, "reset_wrap");
    cyc(0, 1, 0, 0, 0, 0, 1, "wrap_enter");
    for (int i = 0; i < 257; i++) cyc(0, 1, 0, 0, 1, 0, 1, "wrap_tick");
`ifdef TICK_PRESCALER_TICKCNT_EN
    want_final = 8'd1;
`else
    want_final = 8'd0;
`endif
    checks++;
    assert (TICKS === want_final) else begin errors++; $error("FAIL ticks_final TICKS got %0d exp %0d", TICKS, want_final); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
